// File: rtl/turn_scheduler_if.sv
// Handshake bundle between the turn scheduler and its requesters / action counter.
//   master : drives en, req, act_strobe; observes the grant and turn status
//   slave  : the scheduler itself
// Widths derive from N_REQ and MAX_ACTIONS the same way the scheduler derives them.
interface turn_scheduler_if #(
   parameter int N_REQ       = 3,
   parameter int MAX_ACTIONS = 3
);
   localparam int IDW = ($clog2(N_REQ) > 1) ? $clog2(N_REQ) : 1;
   localparam int CW  = $clog2(MAX_ACTIONS + 1);

   logic             en;
   logic [N_REQ-1:0] req;
   logic             act_strobe;
   logic [N_REQ-1:0] grant;
   logic [IDW-1:0]   grant_id;
   logic             busy;
   logic [CW-1:0]    action_cnt;
   logic             turn_done;
   logic [1:0]       done_reason;

   modport master (
      output en, req, act_strobe,
      input  grant, grant_id, busy, action_cnt, turn_done, done_reason
   );

   modport slave (
      input  en, req, act_strobe,
      output grant, grant_id, busy, action_cnt, turn_done, done_reason
   );
endinterface

// File: rtl/turn_scheduler.sv
// Round-robin turn scheduler sharing one action counter between N_REQ requesters.
// One requester is granted at a time; its action strobes are counted and the turn
// ends on abort (en low), action limit, yield (own req dropped) or idle timeout.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset
//   bus    : turn_scheduler_if.slave (en, req, act_strobe in; grant, grant_id,
//            busy, action_cnt, turn_done, done_reason out, all registered)
//
// state  | meaning
// IDLE   | no turn; waits for en && |req, then grants the round-robin winner
// ACTIVE | one requester granted; strobes counted, end conditions watched
// DONE   | one-cycle turn_done pulse with reason, then back to IDLE
module turn_scheduler #(
   parameter int N_REQ       = 3,
   parameter int MAX_ACTIONS = 3,
   parameter int TIMEOUT     = 8
) (
   input logic              clk_i,
   input logic              rst_i,
   turn_scheduler_if.slave  bus
);
   localparam int IDW = ($clog2(N_REQ) > 1) ? $clog2(N_REQ) : 1;
   localparam int CW  = $clog2(MAX_ACTIONS + 1);
   localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [1:0] R_MAX     = 2'b00;
   localparam logic [1:0] R_YIELD   = 2'b01;
   localparam logic [1:0] R_TIMEOUT = 2'b10;
   localparam logic [1:0] R_ABORT   = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [IDW-1:0]   grant_id_q, grant_id_d;
   logic [IDW-1:0]   last_id_q, last_id_d;
   logic             busy_q, busy_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             done_q, done_d;
   logic [1:0]       reason_q, reason_d;
   // Idle timer counts down the strobe-less cycles still allowed in this turn.
   logic [TW-1:0]    tmr_q, tmr_d;

   logic             found;
   logic [IDW-1:0]   win_id;
   logic [IDW-1:0]   cand;

   // Round-robin search starting just after the last granted index.
   always_comb begin
      found  = 1'b0;
      win_id = '0;
      cand   = last_id_q;
      for (int i = 0; i < N_REQ; i++) begin
         cand = (cand == IDW'(N_REQ - 1)) ? '0 : cand + 1'b1;
         if (!found && bus.req[cand]) begin
            found  = 1'b1;
            win_id = cand;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      grant_id_d = grant_id_q;
      last_id_d  = last_id_q;
      busy_d     = busy_q;
      cnt_d      = cnt_q;
      done_d     = 1'b0;
      reason_d   = reason_q;
      tmr_d      = tmr_q;
      case (state_q)
         S_IDLE: begin
            grant_d = '0;
            busy_d  = 1'b0;
            if (bus.en && found) begin
               state_d         = S_ACTIVE;
               grant_d[win_id] = 1'b1;
               grant_id_d      = win_id;
               last_id_d       = win_id;
               busy_d          = 1'b1;
               cnt_d           = '0;
               tmr_d           = TW'(TIMEOUT - 1);
            end
         end
         S_ACTIVE: begin
            // The strobe is counted even when the turn ends in this same cycle.
            if (bus.act_strobe) begin
               cnt_d = cnt_q + 1'b1;
               tmr_d = TW'(TIMEOUT - 1);
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
            if (!bus.en) begin
               state_d  = S_DONE;
               reason_d = R_ABORT;
            end else if (bus.act_strobe && cnt_q == CW'(MAX_ACTIONS - 1)) begin
               state_d  = S_DONE;
               reason_d = R_MAX;
            end else if (!bus.req[grant_id_q]) begin
               state_d  = S_DONE;
               reason_d = R_YIELD;
            end else if (!bus.act_strobe && tmr_q == '0) begin
               state_d  = S_DONE;
               reason_d = R_TIMEOUT;
            end
            if (state_d == S_DONE) begin
               grant_d = '0;
               done_d  = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         grant_q    <= '0;
         grant_id_q <= '0;
         last_id_q  <= IDW'(N_REQ - 1);
         busy_q     <= 1'b0;
         cnt_q      <= '0;
         done_q     <= 1'b0;
         reason_q   <= 2'b00;
         tmr_q      <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         grant_id_q <= grant_id_d;
         last_id_q  <= last_id_d;
         busy_q     <= busy_d;
         cnt_q      <= cnt_d;
         done_q     <= done_d;
         reason_q   <= reason_d;
         tmr_q      <= tmr_d;
      end
   end

   assign bus.grant       = grant_q;
   assign bus.grant_id    = grant_id_q;
   assign bus.busy        = busy_q;
   assign bus.action_cnt  = cnt_q;
   assign bus.turn_done   = done_q;
   assign bus.done_reason = reason_q;
endmodule

// File: tb/tb_turn_scheduler.sv
// Randomized bench for turn_scheduler. A turn-level reference model in the driver
// predicts each grant and each turn result; a separate monitor compares them when
// the DUT raises a grant or pulses turn_done.
module tb_turn_scheduler;
   localparam int N   = 3;
   localparam int MAX = 3;
   localparam int TO  = 8;

   typedef struct {
      int id;
      int reason;
      int cnt;
   } rec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int vectors     = 0;
   int miscompares = 0;

   rec_t exp_q[$];
   int   gnt_q[$];
   int   last_id;

   turn_scheduler_if #(.N_REQ(N), .MAX_ACTIONS(MAX)) bus ();

   turn_scheduler #(.N_REQ(N), .MAX_ACTIONS(MAX), .TIMEOUT(TO)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int pick(input logic [N-1:0] r, input int last);
      int k;
      for (int i = 1; i <= N; i++) begin
         k = (last + i) % N;
         if (r[k]) return k;
      end
      return -1;
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, "_grant"},    int'(bus.grant), 0);
      chk({tag, "_busy"},     int'(bus.busy), 0);
      chk({tag, "_done"},     int'(bus.turn_done), 0);
      chk({tag, "_grant_id"}, int'(bus.grant_id), 0);
      chk({tag, "_cnt"},      int'(bus.action_cnt), 0);
      chk({tag, "_reason"},   int'(bus.done_reason), 0);
   endtask

   // Called at a falling edge while the DUT is idle; returns at a falling edge
   // with the DUT idle again. abort_at >= 0 forces en=0 plus a strobe once that
   // many actions have been counted.
   task automatic run_turn(input logic [N-1:0] req_init, input int strobe_pct,
                           input int abort_pct, input int yield_pct, input int abort_at);
      logic [N-1:0] r;
      int   w, cnt, idle, reason;
      bit   e, s, ended;
      rec_t rec;
      r = (req_init != '0) ? req_init : N'($urandom_range(1, (1 << N) - 1));
      bus.req        = r;
      bus.en         = 1'b1;
      bus.act_strobe = 1'($urandom_range(0, 1));
      w = pick(r, last_id);
      last_id = w;
      gnt_q.push_back(w);
      @(negedge clk);
      cnt   = 0;
      idle  = 0;
      ended = 1'b0;
      while (!ended) begin
         e = ($urandom_range(0, 99) >= abort_pct);
         s = ($urandom_range(0, 99) < strobe_pct);
         r = N'($urandom);
         r[w] = ($urandom_range(0, 99) >= yield_pct);
         if (abort_at == cnt) begin
            e    = 1'b0;
            s    = 1'b1;
            r[w] = 1'b1;
         end
         bus.en         = e;
         bus.act_strobe = s;
         bus.req        = r;
         reason = -1;
         if (!e)                          reason = 3;
         else if (s && cnt == MAX - 1)    reason = 0;
         else if (!r[w])                  reason = 1;
         else if (!s && idle == TO - 1)   reason = 2;
         cnt  = cnt + int'(s);
         idle = s ? 0 : idle + 1;
         if (reason >= 0) begin
            rec.id     = w;
            rec.reason = reason;
            rec.cnt    = cnt;
            exp_q.push_back(rec);
            ended = 1'b1;
         end
         @(negedge clk);
      end
      // DONE cycle: inputs are irrelevant, strobes must not be counted.
      bus.en         = 1'($urandom_range(0, 1));
      bus.req        = N'($urandom);
      bus.act_strobe = 1'($urandom_range(0, 1));
      @(negedge clk);
   endtask

   task automatic idle_gap();
      int n;
      n = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) begin
         bus.act_strobe = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 0) begin
            bus.en  = 1'b1;
            bus.req = '0;
         end else begin
            bus.en  = 1'b0;
            bus.req = N'($urandom);
         end
         @(negedge clk);
      end
   endtask

   // Monitor: consumes expected grants and turn results as the DUT presents them.
   initial begin : monitor
      logic [N-1:0] prev_grant;
      bit           held;
      rec_t         r;
      int           g;
      prev_grant = '0;
      held       = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.grant != '0 && prev_grant == '0) begin
            if (gnt_q.size() == 0) begin
               chk("spurious_grant", int'(bus.grant), 0);
            end else begin
               g = gnt_q.pop_front();
               chk("grant_onehot", int'(bus.grant), 1 << g);
               chk("grant_id", int'(bus.grant_id), g);
               chk("grant_cnt_zero", int'(bus.action_cnt), 0);
            end
         end
         if (bus.grant != '0) begin
            chk("busy_in_active", int'(bus.busy), 1);
            if (bus.action_cnt > CW_MAX()) chk("cnt_bound", int'(bus.action_cnt), MAX);
         end
         if (bus.turn_done) begin
            if (exp_q.size() == 0) begin
               chk("spurious_turn_done", 1, 0);
            end else begin
               r = exp_q.pop_front();
               chk("done_id", int'(bus.grant_id), r.id);
               chk("done_reason", int'(bus.done_reason), r.reason);
               chk("done_cnt", int'(bus.action_cnt), r.cnt);
               chk("done_grant_zero", int'(bus.grant), 0);
               chk("done_busy", int'(bus.busy), 1);
               held = 1'b1;
            end
         end else if (held) begin
            chk("hold_id", int'(bus.grant_id), r.id);
            chk("hold_reason", int'(bus.done_reason), r.reason);
            chk("hold_cnt", int'(bus.action_cnt), r.cnt);
            chk("idle_busy", int'(bus.busy), 0);
            held = 1'b0;
         end
         prev_grant = bus.grant;
      end
   end

   function automatic int CW_MAX();
      return MAX;
   endfunction

   initial begin : driver
      bus.en         = 1'b1;
      bus.req        = '1;
      bus.act_strobe = 1'b0;
      rst            = 1'b1;
      last_id        = N - 1;
      for (int c = 0; c < 2; c++) begin
         @(posedge clk);
         @(negedge clk);
         chk_all_zero("reset");
      end
      rst = 1'b0;
      // Full turns with everybody requesting: grants rotate 0,1,2,0.
      for (int t = 0; t < 4; t++) run_turn('1, 100, 0, 0, -1);
      // Abort together with the final strobe: counted, reason ABORT.
      run_turn('1, 100, 0, 0, MAX - 1);
      // Pure timeout turn.
      run_turn('1, 0, 0, 0, -1);
      for (int t = 0; t < 60; t++) begin
         idle_gap();
         case (t % 4)
            0: run_turn('0, 100, 0, 0, -1);
            1: run_turn('0, 0, 0, 0, -1);
            2: run_turn('0, 40, 3, 8, -1);
            default: run_turn('0, 30, 2, 25, -1);
         endcase
      end
      // Reset in the middle of requester 1's turn.
      bus.en         = 1'b1;
      bus.req        = 3'b010;
      bus.act_strobe = 1'b0;
      gnt_q.push_back(1);
      last_id = 1;
      @(negedge clk);
      bus.act_strobe = 1'b1;
      @(negedge clk);
      bus.act_strobe = 1'b0;
      bus.req        = '1;
      rst            = 1'b1;
      @(negedge clk);
      chk_all_zero("midreset");
      rst     = 1'b0;
      last_id = N - 1;
      run_turn('1, 100, 0, 0, -1);
      bus.en  = 1'b0;
      bus.req = '0;
      repeat (4) @(negedge clk);
      chk("pending_turns", exp_q.size(), 0);
      chk("pending_grants", gnt_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
